sync_fifo: RTL and testbench

//  Single-clock synchronous FIFO. It is the buffering stage driven by the fifo test environment through fifo_if.
//  The producer writes via wr/data. The consumer pops via rd and samples the registered q one cycle later.

---
 rtl/fifo_pkg.sv | 26 ++
 rtl/fifo_mem.sv | 37 +++
 rtl/sync_fifo.sv | 133 +++++++++++++
 tb/tb_sync_fifo.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and sizing helpers for the synchronous FIFO.
//   fifo_cmd_e     - operation accepted in a given cycle
//   ptr_width()    - pointer width: one extra wrap bit above the address bits
//   count_width()  - occupancy width, able to hold 0..DEPTH
//   DATA_WIDTH_DEF / DEPTH_DEF - default geometry
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int DEPTH_DEF      = 16;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PUSH     = 2'd1,
      POP      = 2'd2,
      PUSH_POP = 2'd3
   } fifo_cmd_e;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: 1-write / 1-read register array with a registered read port.
// Ports:
//   clk    - clock
//   we     - write enable; wdata is stored at waddr on posedge
//   waddr  - write address
//   wdata  - write data
//   re     - read enable; rdata loads mem[raddr] on posedge, else holds
//   raddr  - read address
//   rdata  - registered read data
// Contents are deliberately not reset so the array maps onto block RAM.
// A same-edge read and write to one address returns the old contents.
module fifo_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and registered flags.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   wr, data     - write request and data
//   rd           - read request; q updates on the accepting edge
//   q            - registered read data (0 after reset until the first read)
//   full, mty    - occupancy == DEPTH / == 0
//   almost_full  - count >= AF_LEVEL
//   almost_mty   - count <= AE_LEVEL
//   count        - occupancy 0..DEPTH
//   ovf, udf     - one-cycle pulses for a dropped write / rejected read
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int AF_LEVEL   = 14,
   parameter int AE_LEVEL   = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          wr,
   input  logic [DATA_WIDTH-1:0]         data,
   input  logic                          rd,
   output logic [DATA_WIDTH-1:0]         q,
   output logic                          full,
   output logic                          mty,
   output logic                          almost_full,
   output logic                          almost_mty,
   output logic [count_width(DEPTH)-1:0] count,
   output logic                          ovf,
   output logic                          udf
);

   localparam int PW = ptr_width(DEPTH);
   localparam int CW = count_width(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic          full_reg, mty_reg, af_reg, ae_reg, ovf_reg, udf_reg;
   logic          q_valid_reg;
   logic          wr_ok, rd_ok;
   logic [DATA_WIDTH-1:0] mem_rdata;
   fifo_cmd_e     cmd;

   // A read frees a slot on the same edge, so a full FIFO still accepts a
   // write paired with a read. An empty FIFO never forwards write data.
   assign wr_ok = wr && (!full_reg || rd);
   assign rd_ok = rd && !mty_reg;

   always_comb begin
      cmd = IDLE;
      case ({wr_ok, rd_ok})
         2'b10:   cmd = PUSH;
         2'b01:   cmd = POP;
         2'b11:   cmd = PUSH_POP;
         default: cmd = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      case (cmd)
         PUSH:     wr_ptr_next = wr_ptr_reg + 1'b1;
         POP:      rd_ptr_next = rd_ptr_reg + 1'b1;
         PUSH_POP: begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
            rd_ptr_next = rd_ptr_reg + 1'b1;
         end
         default: ;
      endcase
      count_next = CW'(wr_ptr_next - rd_ptr_next);
   end

   // Flags are computed from the next pointers so they change on the same
   // edge as the pointers themselves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         count_reg   <= '0;
         full_reg    <= 1'b0;
         mty_reg     <= 1'b1;
         af_reg      <= 1'b0;
         ae_reg      <= 1'b1;
         ovf_reg     <= 1'b0;
         udf_reg     <= 1'b0;
         q_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         count_reg   <= count_next;
         full_reg    <= (wr_ptr_next[PW-1] != rd_ptr_next[PW-1]) &&
                        (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);
         mty_reg     <= (wr_ptr_next == rd_ptr_next);
         af_reg      <= (count_next >= CW'(AF_LEVEL));
         ae_reg      <= (count_next <= CW'(AE_LEVEL));
         ovf_reg     <= wr && full_reg && !rd;
         udf_reg     <= rd && mty_reg;
         q_valid_reg <= q_valid_reg || rd_ok;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) u_mem (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_ptr_reg[AW-1:0]),
      .wdata (data),
      .re    (rd_ok),
      .raddr (rd_ptr_reg[AW-1:0]),
      .rdata (mem_rdata)
   );

   // The memory read register has no reset; q is forced to 0 until a read
   // has been accepted since the last reset, which makes reset take effect
   // on q immediately.
   assign q           = q_valid_reg ? mem_rdata : '0;
   assign full        = full_reg;
   assign mty         = mty_reg;
   assign almost_full = af_reg;
   assign almost_mty  = ae_reg;
   assign count       = count_reg;
   assign ovf         = ovf_reg;
   assign udf         = udf_reg;

endmodule

// File: tb/tb_sync_fifo.sv
module tb_sync_fifo;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AFL   = 14;
   localparam int AEL   = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wr = 1'b0;
   logic          rd = 1'b0;
   logic [DW-1:0] data = '0;
   logic [DW-1:0] q;
   logic          full, mty, almost_full, almost_mty, ovf, udf;
   logic [4:0]    count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [DW-1:0] mq[$];
   logic [DW-1:0] q_exp;
   logic          ovf_exp, udf_exp;

   always #5 clk = ~clk;

   sync_fifo #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .AF_LEVEL   (AFL),
      .AE_LEVEL   (AEL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr          (wr),
      .data        (data),
      .rd          (rd),
      .q           (q),
      .full        (full),
      .mty         (mty),
      .almost_full (almost_full),
      .almost_mty  (almost_mty),
      .count       (count),
      .ovf         (ovf),
      .udf         (udf)
   );

   task automatic check_eq(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      q_exp   = '0;
      ovf_exp = 1'b0;
      udf_exp = 1'b0;
   endtask

   task automatic check_state(input string tag);
      int n;
      n = mq.size();
      check_eq({tag, ".count"}, int'(count), n);
      check_eq({tag, ".full"},  int'(full), int'(n == DEPTH));
      check_eq({tag, ".mty"},   int'(mty), int'(n == 0));
      check_eq({tag, ".af"},    int'(almost_full), int'(n >= AFL));
      check_eq({tag, ".ae"},    int'(almost_mty), int'(n <= AEL));
      check_eq({tag, ".q"},     int'(q), int'(q_exp));
      check_eq({tag, ".ovf"},   int'(ovf), int'(ovf_exp));
      check_eq({tag, ".udf"},   int'(udf), int'(udf_exp));
   endtask

   // One clock cycle: drive, predict, clock, check. Called at posedge+1.
   task automatic do_cycle(input string tag, input logic w, input logic r, input logic [DW-1:0] d);
      int  n;
      logic rd_ok, wr_ok;
      wr   = w;
      rd   = r;
      data = d;
      n       = mq.size();
      rd_ok   = r && (n > 0);
      wr_ok   = w && ((n < DEPTH) || r);
      ovf_exp = w && (n == DEPTH) && !r;
      udf_exp = r && (n == 0);
      if (rd_ok) q_exp = mq.pop_front();
      if (wr_ok) mq.push_back(d);
      @(posedge clk);
      #1;
      $display("%s wr=%0b rd=%0b data=%02h -> q=%02h count=%0d full=%0b mty=%0b ovf=%0b udf=%0b",
               tag, w, r, d, q, count, full, mty, ovf, udf);
      check_state(tag);
      wr = 1'b0;
      rd = 1'b0;
   endtask

   initial begin
      logic [DW-1:0] saved [DEPTH];
      model_reset();
      #12;
      check_state("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 1: fill with random bytes
      for (int i = 0; i < DEPTH; i++) do_cycle("t1", 1'b1, 1'b0, DW'($urandom));
      check_eq("t1_full", int'(full), 1);
      for (int i = 0; i < DEPTH; i++) do_cycle("t1_drain", 1'b0, 1'b1, '0);

      // 2: two writes, two reads
      do_cycle("t2", 1'b1, 1'b0, 8'hA5);
      do_cycle("t2", 1'b1, 1'b0, 8'h3C);
      do_cycle("t2", 1'b0, 1'b1, '0);
      check_eq("t2_q1", int'(q), 8'hA5);
      do_cycle("t2", 1'b0, 1'b1, '0);
      check_eq("t2_q2", int'(q), 8'h3C);
      check_eq("t2_mty", int'(mty), 1);

      // 3: overflow on a full FIFO
      for (int i = 0; i < DEPTH; i++) begin
         saved[i] = DW'($urandom_range(0, 254));
         do_cycle("t3_fill", 1'b1, 1'b0, saved[i]);
      end
      do_cycle("t3_ovf", 1'b1, 1'b0, 8'hFF);
      check_eq("t3_ovf_pulse", int'(ovf), 1);
      do_cycle("t3_idle", 1'b0, 1'b0, '0);
      check_eq("t3_ovf_clear", int'(ovf), 0);
      for (int i = 0; i < DEPTH; i++) begin
         do_cycle("t3_read", 1'b0, 1'b1, '0);
         check_eq("t3_data", int'(q), int'(saved[i]));
      end

      // 4: underflow
      do_cycle("t4_udf", 1'b0, 1'b1, '0);
      check_eq("t4_udf_pulse", int'(udf), 1);
      do_cycle("t4_wrrd", 1'b1, 1'b1, 8'h11);
      check_eq("t4_count", int'(count), 1);
      do_cycle("t4_read", 1'b0, 1'b1, '0);
      check_eq("t4_q", int'(q), 8'h11);

      // 5: full FIFO streaming across wrap
      for (int i = 0; i < DEPTH; i++) do_cycle("t5_fill", 1'b1, 1'b0, DW'(i));
      for (int i = 0; i < 40; i++) begin
         do_cycle("t5_stream", 1'b1, 1'b1, DW'(DEPTH + i));
         check_eq("t5_q", int'(q), i);
      end
      for (int i = 0; i < DEPTH; i++) do_cycle("t5_drain", 1'b0, 1'b1, '0);

      // 6: asynchronous reset mid-operation
      for (int i = 0; i < 9; i++) do_cycle("t6_fill", 1'b1, 1'b0, DW'($urandom));
      do_cycle("t6_read", 1'b0, 1'b1, '0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state("t6_rst");
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_cycle("t6_wr", 1'b1, 1'b0, 8'h77);
      do_cycle("t6_rd", 1'b0, 1'b1, '0);
      check_eq("t6_q", int'(q), 8'h77);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         do_cycle("rand", ($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50), DW'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
